// File: rtl/sprite_blitter_pkg.sv
// Shared framebuffer geometry and blitter state encoding for the Chip-8 display path.
// Both the blitter and its bus interface import this package.
package chip8_fb_pkg;
  localparam int LORES_W   = 64;
  localparam int LORES_H   = 32;
  localparam int HIRES_W   = 128;
  localparam int HIRES_H   = 64;
  localparam int LORES_WPL = 4;
  localparam int HIRES_WPL = 8;
  localparam int FB_ADDR_W = 9;

  typedef enum logic [3:0] {
    IDLE, FETCH_ADDR, FETCH_DATA, FETCH2_ADDR, FETCH2_DATA,
    RD_A, WR_A, RD_B, WR_B, DONE, CLR
  } blitState_t;
endpackage

// File: rtl/sprite_blitter_if.sv
// Main-memory read port plus framebuffer port B, as seen from the blitter (master).
interface sprite_blitter_if import chip8_fb_pkg::*; #(parameter int MEM_ADDR_W = 12);
  logic [MEM_ADDR_W-1:0] memAddr;
  logic                  memRd;
  logic [7:0]            memData;
  logic [FB_ADDR_W-1:0]  fbAddr;
  logic [15:0]           fbRdData;
  logic [15:0]           fbWrData;
  logic                  fbWe;

  modport master (output memAddr, memRd, fbAddr, fbWrData, fbWe,
                  input  memData, fbRdData);
  modport slave  (input  memAddr, memRd, fbAddr, fbWrData, fbWe,
                  output memData, fbRdData);
endinterface

// File: rtl/sprite_row_aligner.sv
// Shifts a 16-pixel sprite row across two framebuffer words; bit 15 is the leftmost pixel.
module sprite_row_aligner (
  input  logic [15:0] row16,
  input  logic [3:0]  shift,
  output logic [15:0] maskA,
  output logic [15:0] maskB
);
  logic [31:0] pix32;

  assign pix32 = {row16, 16'h0000} >> shift;
  assign maskA = pix32[31:16];
  assign maskB = pix32[15:0];
endmodule

// File: rtl/sprite_blitter.sv
// DXYN / CLS write engine: fetches sprite rows, XORs them into the framebuffer and reports collision.
module sprite_blitter import chip8_fb_pkg::*; #(
  parameter bit WRAP_EDGES = 1'b0,
  parameter int MEM_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  hires,
  input  logic                  start,
  input  logic                  clear,
  input  logic [6:0]            x,
  input  logic [5:0]            y,
  input  logic [3:0]            n,
  input  logic [MEM_ADDR_W-1:0] spriteAddr,
  sprite_blitter_if.master      bus,
  output logic                  busy,
  output logic                  done,
  output logic                  collision
);
  blitState_t state, stateNext;

  logic                  hiresR, wideR;
  logic [MEM_ADDR_W-1:0] baseR;
  logic [4:0]            rowsR, rowIdx;
  logic [6:0]            x0;
  logic [5:0]            y0;
  logic [15:0]           row16;
  logic [FB_ADDR_W-1:0]  clrAddr;
  logic                  collisionR;

  logic [6:0]            line, nextLine;
  logic [FB_ADDR_W-1:0]  lineBase, wA, wB, clrLast;
  logic [2:0]            wordIdx;
  logic                  lastWord, skipB, lastRow, rowAdvance, hitA, hitB;
  logic [5:0]            byteIdx;
  logic [MEM_ADDR_W-1:0] fetchAddr;
  logic [15:0]           maskA, maskB;

  sprite_row_aligner aligner (.row16(row16), .shift(x0[3:0]), .maskA(maskA), .maskB(maskB));

  // Line before wrap is at most 63+15, so 7 bits hold it; the wrapped line feeds the word base.
  assign line      = {1'b0, y0} + {2'b00, rowIdx};
  assign nextLine  = line + 7'd1;
  assign lineBase  = hiresR ? {line[5:0], 3'b000} : {2'b00, line[4:0], 2'b00};
  assign wordIdx   = x0[6:4];
  assign wA        = lineBase + {6'd0, wordIdx};
  assign lastWord  = hiresR ? (wordIdx == 3'(HIRES_WPL - 1)) : (wordIdx == 3'(LORES_WPL - 1));
  assign wB        = lastWord ? lineBase : wA + 9'd1;
  assign skipB     = (maskB == 16'h0000) || (lastWord && !WRAP_EDGES);
  assign lastRow   = ((rowIdx + 5'd1) == rowsR) ||
                     (!WRAP_EDGES && (nextLine >= (hiresR ? 7'(HIRES_H) : 7'(LORES_H))));
  assign byteIdx   = wideR ? {rowIdx, 1'b0} : {1'b0, rowIdx};
  assign fetchAddr = baseR + MEM_ADDR_W'(byteIdx);
  assign clrLast   = hiresR ? 9'd511 : 9'd127;
  assign hitA      = |(bus.fbRdData & maskA);
  assign hitB      = |(bus.fbRdData & maskB);
  assign busy      = (state != IDLE);
  assign collision = collisionR;

  always_ff @(posedge clk) begin
    if (res) state <= IDLE;
    else     state <= stateNext;
  end

  // Clear has priority over start; neither is looked at outside IDLE.
  always_comb begin
    stateNext    = state;
    bus.memRd    = 1'b0;
    bus.memAddr  = '0;
    bus.fbAddr   = '0;
    bus.fbWrData = '0;
    bus.fbWe     = 1'b0;
    done         = 1'b0;
    rowAdvance   = 1'b0;
    case (state)
      IDLE: begin
        if (clear)      stateNext = CLR;
        else if (start) stateNext = FETCH_ADDR;
      end
      FETCH_ADDR: begin
        bus.memRd   = 1'b1;
        bus.memAddr = fetchAddr;
        stateNext   = FETCH_DATA;
      end
      FETCH_DATA:  stateNext = wideR ? FETCH2_ADDR : RD_A;
      FETCH2_ADDR: begin
        bus.memRd   = 1'b1;
        bus.memAddr = fetchAddr + MEM_ADDR_W'(1);
        stateNext   = FETCH2_DATA;
      end
      FETCH2_DATA: stateNext = RD_A;
      RD_A: begin
        bus.fbAddr = wA;
        stateNext  = WR_A;
      end
      WR_A: begin
        bus.fbAddr   = wA;
        bus.fbWrData = bus.fbRdData ^ maskA;
        bus.fbWe     = 1'b1;
        if (skipB) begin
          rowAdvance = 1'b1;
          stateNext  = lastRow ? DONE : FETCH_ADDR;
        end else begin
          stateNext  = RD_B;
        end
      end
      RD_B: begin
        bus.fbAddr = wB;
        stateNext  = WR_B;
      end
      WR_B: begin
        bus.fbAddr   = wB;
        bus.fbWrData = bus.fbRdData ^ maskB;
        bus.fbWe     = 1'b1;
        rowAdvance   = 1'b1;
        stateNext    = lastRow ? DONE : FETCH_ADDR;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      CLR: begin
        bus.fbAddr = clrAddr;
        bus.fbWe   = 1'b1;
        if (clrAddr == clrLast) stateNext = DONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operands are reduced modulo the field size on start so the draw never sees an out-of-field origin.
  always_ff @(posedge clk) begin
    if (res) begin
      hiresR <= 1'b0; wideR <= 1'b0; baseR <= '0; rowsR <= '0; rowIdx <= '0;
      x0 <= '0; y0 <= '0; row16 <= '0; clrAddr <= '0; collisionR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            hiresR     <= hires;
            clrAddr    <= '0;
            collisionR <= 1'b0;
          end else if (start) begin
            hiresR     <= hires;
            wideR      <= hires && (n == 4'd0);
            baseR      <= spriteAddr;
            rowsR      <= (n == 4'd0) ? 5'd16 : {1'b0, n};
            x0         <= hires ? x : {1'b0, x[5:0]};
            y0         <= hires ? y : {1'b0, y[4:0]};
            rowIdx     <= '0;
            collisionR <= 1'b0;
          end
        end
        FETCH_DATA:  row16      <= {bus.memData, 8'h00};
        FETCH2_DATA: row16[7:0] <= bus.memData;
        WR_A: begin
          if (hitA)       collisionR <= 1'b1;
          if (rowAdvance) rowIdx     <= rowIdx + 5'd1;
        end
        WR_B: begin
          if (hitB)       collisionR <= 1'b1;
          if (rowAdvance) rowIdx     <= rowIdx + 5'd1;
        end
        CLR: clrAddr <= clrAddr + 9'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench: two blitters (clip and wrap) share memory contents; a monitor checks every write and done.
module tb_sprite_blitter;
  import chip8_fb_pkg::*;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        hires = 1'b0;
  logic        start0 = 1'b0, clear0 = 1'b0, start1 = 1'b0, clear1 = 1'b0;
  logic [6:0]  x = '0;
  logic [5:0]  y = '0;
  logic [3:0]  n = '0;
  logic [11:0] spriteAddr = '0;
  logic        busy0, done0, coll0, busy1, done1, coll1;

  sprite_blitter_if #(.MEM_ADDR_W(12)) bus0 ();
  sprite_blitter_if #(.MEM_ADDR_W(12)) bus1 ();

  sprite_blitter #(.WRAP_EDGES(1'b0), .MEM_ADDR_W(12)) dut0 (
    .clk(clk), .res(res), .hires(hires), .start(start0), .clear(clear0),
    .x(x), .y(y), .n(n), .spriteAddr(spriteAddr), .bus(bus0),
    .busy(busy0), .done(done0), .collision(coll0));

  sprite_blitter #(.WRAP_EDGES(1'b1), .MEM_ADDR_W(12)) dut1 (
    .clk(clk), .res(res), .hires(hires), .start(start1), .clear(clear1),
    .x(x), .y(y), .n(n), .spriteAddr(spriteAddr), .bus(bus1),
    .busy(busy1), .done(done1), .collision(coll1));

  always #5 clk = ~clk;

  logic [7:0]  mem [4096];
  logic [15:0] fb0 [512];
  logic [15:0] fb1 [512];

  always @(posedge clk) begin
    bus0.memData  <= mem[bus0.memAddr];
    bus1.memData  <= mem[bus1.memAddr];
    bus0.fbRdData <= fb0[bus0.fbAddr];
    bus1.fbRdData <= fb1[bus1.fbAddr];
    if (bus0.fbWe) fb0[bus0.fbAddr] <= bus0.fbWrData;
    if (bus1.fbWe) fb1[bus1.fbAddr] <= bus1.fbWrData;
  end

  typedef struct { int dut; int addr; int data; int cyc; } wrExp_t;
  typedef struct { int dut; int coll; int cyc; } doneExp_t;
  wrExp_t   wrQ[$];
  doneExp_t doneQ[$];

  int tests = 0, fails = 0, cyc = 0, startCyc = 0, memRdCount = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus0.memRd) memRdCount <= memRdCount + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitorPort(input int d, input logic we, input int addr, input int data,
                             input logic dn, input logic coll);
    wrExp_t e;
    doneExp_t de;
    if (we) begin
      if (wrQ.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpected write: dut%0d addr 0x%0h data 0x%0h, none expected", d, addr, data);
      end else begin
        e = wrQ.pop_front();
        checkOutput("write dut/addr", d * 1024 + addr, e.dut * 1024 + e.addr);
        checkOutput("write data", data, e.data);
        if (e.cyc >= 0) checkOutput("write cycle", cyc - startCyc, e.cyc);
      end
    end
    if (dn) begin
      if (doneQ.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpected done: dut%0d collision %0d, none expected", d, coll);
      end else begin
        de = doneQ.pop_front();
        checkOutput("done dut/collision", d * 2 + int'(coll), de.dut * 2 + de.coll);
        if (de.cyc >= 0) checkOutput("done cycle", cyc - startCyc, de.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      monitorPort(0, bus0.fbWe, int'(bus0.fbAddr), int'(bus0.fbWrData), done0, coll0);
      monitorPort(1, bus1.fbWe, int'(bus1.fbAddr), int'(bus1.fbWrData), done1, coll1);
    end
  end

  task automatic expWr(input int d, input int addr, input int data, input int c);
    wrExp_t e;
    e.dut = d; e.addr = addr; e.data = data; e.cyc = c;
    wrQ.push_back(e);
  endtask

  task automatic expDone(input int d, input int coll, input int c);
    doneExp_t e;
    e.dut = d; e.coll = coll; e.cyc = c;
    doneQ.push_back(e);
  endtask

  task automatic applyStimulus(input int d, input logic h, input int xv, input int yv, input int nv,
                               input int addr, input logic doStart, input logic doClear);
    @(negedge clk);
    hires = h; x = 7'(xv); y = 6'(yv); n = 4'(nv); spriteAddr = 12'(addr);
    if (d == 0) begin start0 = doStart; clear0 = doClear; end
    else        begin start1 = doStart; clear1 = doClear; end
    startCyc = cyc;
    @(negedge clk);
    start0 = 1'b0; clear0 = 1'b0; start1 = 1'b0; clear1 = 1'b0;
  endtask

  task automatic waitDone(input int d);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ((d == 0) ? done0 : done1) break;
    end
    if (k == 3000) begin
      tests++; fails++;
      $display("[TB] FAIL done timeout: dut%0d no done within 3000 cycles", d);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    for (int i = 0; i < 512; i++) begin fb0[i] = 16'h0000; fb1[i] = 16'h0000; end
    mem[12'h200] = 8'hF0;
    mem[12'h201] = 8'hFF;
    mem[12'h202] = 8'h81;
    mem[12'h203] = 8'h7E;
    for (int r = 0; r < 16; r++) begin
      mem[12'h300 + 2 * r]     = 8'hA5;
      mem[12'h300 + 2 * r + 1] = 8'h3C;
    end

    repeat (3) @(negedge clk);
    checkOutput("reset busy", int'(busy0), 0);
    checkOutput("reset done", int'(done0), 0);
    checkOutput("reset collision", int'(coll0), 0);
    checkOutput("reset fbWe", int'(bus0.fbWe), 0);
    checkOutput("reset memRd", int'(bus0.memRd), 0);
    checkOutput("reset fbAddr", int'(bus0.fbAddr), 0);
    res = 1'b0;

    // Aligned lores draw with exact write/done timing.
    expWr(0, 0, 16'hF000, 4); expDone(0, 0, 5);
    applyStimulus(0, 1'b0, 0, 0, 1, 12'h200, 1'b1, 1'b0);
    waitDone(0);

    // Straddling two words, then the same sprite again to erase it.
    expWr(0, 4, 16'h000F, -1); expWr(0, 5, 16'hF000, -1); expDone(0, 0, -1);
    applyStimulus(0, 1'b0, 12, 1, 1, 12'h201, 1'b1, 1'b0);
    waitDone(0);
    expWr(0, 4, 16'h0000, -1); expWr(0, 5, 16'h0000, -1); expDone(0, 1, -1);
    applyStimulus(0, 1'b0, 12, 1, 1, 12'h201, 1'b1, 1'b0);
    waitDone(0);

    // Right edge: clipped on dut0, wrapped to word 0 on dut1.
    expWr(0, 3, 16'h000F, -1); expDone(0, 0, -1);
    applyStimulus(0, 1'b0, 60, 0, 1, 12'h201, 1'b1, 1'b0);
    waitDone(0);
    expWr(1, 3, 16'h000F, -1); expWr(1, 0, 16'hF000, -1); expDone(1, 0, -1);
    applyStimulus(1, 1'b0, 60, 0, 1, 12'h201, 1'b1, 1'b0);
    waitDone(1);

    // Bottom edge clip: only line 31 is drawn.
    expWr(0, 124, 16'h8100, -1); expDone(0, 0, -1);
    applyStimulus(0, 1'b0, 0, 31, 3, 12'h202, 1'b1, 1'b0);
    waitDone(0);

    // Hires 16x16 sprite at x=4: row 0xA53C shifted by 4 gives 0x0A53 / 0xC000.
    for (int r = 0; r < 16; r++) begin
      expWr(0, (10 + r) * 8, 16'h0A53, -1);
      expWr(0, (10 + r) * 8 + 1, 16'hC000, -1);
    end
    expDone(0, 0, -1);
    memRdCount = 0;
    applyStimulus(0, 1'b1, 4, 10, 0, 12'h300, 1'b1, 1'b0);
    waitDone(0);
    checkOutput("hires memRd count", memRdCount, 32);

    // A second start while busy must be ignored.
    expWr(0, 0, 16'h0000, -1); expDone(0, 1, -1);
    applyStimulus(0, 1'b0, 0, 0, 1, 12'h200, 1'b1, 1'b0);
    @(negedge clk);
    x = 7'd32; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    waitDone(0);
    checkOutput("collision held after done", int'(coll0), 1);

    // Start and clear together: clear wins (lores field, 128 words).
    for (int i = 0; i < 128; i++) expWr(0, i, 0, -1);
    expDone(0, 0, -1);
    applyStimulus(0, 1'b0, 0, 0, 1, 12'h200, 1'b1, 1'b1);
    waitDone(0);
    checkOutput("fb0 line 31 after clear", int'(fb0[124]), 0);

    // Hires clear on the wrap instance covers all 512 words.
    for (int i = 0; i < 512; i++) expWr(1, i, 0, -1);
    expDone(1, 0, -1);
    applyStimulus(1, 1'b1, 0, 0, 0, 12'h200, 1'b0, 1'b1);
    waitDone(1);

    // Reset during a draw aborts immediately with no write and no done.
    applyStimulus(0, 1'b0, 0, 0, 2, 12'h200, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    checkOutput("abort fbWe", int'(bus0.fbWe), 0);
    checkOutput("abort busy", int'(busy0), 0);
    res = 1'b0;
    repeat (10) @(negedge clk);

    checkOutput("write queue drained", wrQ.size(), 0);
    checkOutput("done queue drained", doneQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
